// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: frames a byte stream as preamble/SFD/payload[/pad]/FCS, then holds inter-frame gap.
// Latency: accepted byte appears on gmii_txd one cycle later; tx_en rises one cycle after s_valid seen in IDLE.
// Backpressure: s_ready high only in DATA; a missing byte there aborts the frame with one tx_er cycle.
//
// Ports:
//   clock, reset                : 125 MHz GMII tx clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready : payload byte stream from the packet source
//   gmii_txd/gmii_tx_en/gmii_tx_er: registered GMII transmit outputs to the PCS/PMA
//   tx_busy                      : high in every state except IDLE
//   frames_sent/underruns        : wrapping 16-bit completed/aborted frame counters
// Build option: define GMII_TX_PAD_EN to pad short frames with zeros up to MIN_FRAME bytes.
module gmii_tx_mac #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic [15:0] frames_sent,
    output logic [15:0] underruns
);

    localparam logic [15:0] PRE_W = 16'(PREAMBLE_LEN);
    localparam logic [15:0] IFG_W = 16'(IFG_BYTES);
`ifdef GMII_TX_PAD_EN
    localparam logic [15:0] MIN_W = 16'(MIN_FRAME);
`else
    logic unused_min_frame;
    assign unused_min_frame = (MIN_FRAME != 0);
`endif

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

    state_t      state_q;
    logic [15:0] step_q;      // preamble / FCS byte / IFG cycle counter
    logic [15:0] len_q;       // payload+pad bytes sent, saturating
    logic [31:0] crc_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [15:0] frames_q;
    logic [15:0] underruns_q;

    logic [31:0] crc_d;
    logic [15:0] len_d;
    logic [7:0]  crc_din;
    logic [7:0]  fcs_byte;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_din  = (state_q == PAD) ? 8'h00 : s_data;
    assign crc_d    = crc32_byte(crc_q, crc_din);
    assign len_d    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign fcs_byte = 8'((~crc_q) >> {step_q[1:0], 3'b000});

    assign s_ready     = (state_q == DATA) && !reset;
    assign tx_busy     = (state_q != IDLE);
    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = tx_en_q;
    assign gmii_tx_er  = tx_er_q;
    assign frames_sent = frames_q;
    assign underruns   = underruns_q;

    // The state names what is being loaded into the output registers this
    // cycle, so the wire shows it one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= 16'd0;
            len_q       <= 16'd0;
            crc_q       <= 32'hFFFFFFFF;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            frames_q    <= 16'd0;
            underruns_q <= 16'd0;
        end else begin
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        txd_q   <= 8'h55;
                        tx_en_q <= 1'b1;
                        step_q  <= 16'd1;
                        state_q <= (PRE_W > 16'd1) ? PREAMBLE : SFD;
                    end
                end
                PREAMBLE: begin
                    txd_q   <= 8'h55;
                    tx_en_q <= 1'b1;
                    step_q  <= step_q + 16'd1;
                    if (step_q >= PRE_W - 16'd1) begin
                        state_q <= SFD;
                    end
                end
                SFD: begin
                    txd_q   <= 8'hD5;
                    tx_en_q <= 1'b1;
                    crc_q   <= 32'hFFFFFFFF;
                    len_q   <= 16'd0;
                    state_q <= DATA;
                end
                DATA: begin
                    tx_en_q <= 1'b1;
                    step_q  <= 16'd0;
                    if (s_valid) begin
                        txd_q <= s_data;
                        crc_q <= crc_d;
                        len_q <= len_d;
                        if (s_last) begin
`ifdef GMII_TX_PAD_EN
                            state_q <= (len_d < MIN_W) ? PAD : FCS;
`else
                            state_q <= FCS;
`endif
                        end
                    end else begin
                        // Source starved mid-frame: poison the frame, skip FCS.
                        tx_er_q     <= 1'b1;
                        underruns_q <= underruns_q + 16'd1;
                        state_q     <= IFG;
                    end
                end
`ifdef GMII_TX_PAD_EN
                PAD: begin
                    tx_en_q <= 1'b1;
                    crc_q   <= crc_d;
                    len_q   <= len_d;
                    if (len_d >= MIN_W) begin
                        state_q <= FCS;
                    end
                end
`endif
                FCS: begin
                    txd_q   <= fcs_byte;
                    tx_en_q <= 1'b1;
                    step_q  <= step_q + 16'd1;
                    if (step_q[1:0] == 2'd3) begin
                        step_q   <= 16'd0;
                        frames_q <= frames_q + 16'd1;
                        state_q  <= IFG;
                    end
                end
                IFG: begin
                    step_q <= step_q + 16'd1;
                    if (step_q >= IFG_W - 16'd1) begin
                        step_q  <= 16'd0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_mac.sv
// Directed bench for gmii_tx_mac: frame contents, FCS, IFG spacing, underrun, mid-frame reset.
// Latency: checks tx_en rise one cycle after s_valid is first seen in IDLE.
// Backpressure: a queue-fed source obeys s_ready; hole entries inject one-cycle s_valid drops.
module tb_gmii_tx_mac;

`ifdef GMII_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        tx_busy;
    logic [15:0] frames_sent;
    logic [15:0] underruns;

    gmii_tx_mac dut (
        .clock       (clock),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .tx_busy     (tx_busy),
        .frames_sent (frames_sent),
        .underruns   (underruns)
    );

    always #4 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       hole;
        logic       last;
        logic [7:0] d;
    } ent_t;

    ent_t       src_q[$];
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_er_cnt;
    int         rx_er_last;
    bit         rx_busy_all;
    bit         rx_ok;
    int         rx_start_cyc;
    int         gap;

    // Source: pops on a handshake seen in the previous cycle, drives after the edge.
    initial begin : source
        logic hs;
        ent_t tmp;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        forever begin
            @(negedge clock);
            hs = s_valid & s_ready;
            @(posedge clock);
            #1;
            if (hs && src_q.size() > 0) tmp = src_q.pop_front();
            if (src_q.size() > 0 && src_q[0].hole) begin
                tmp = src_q.pop_front();
                s_valid = 1'b0;
                s_last  = 1'b0;
            end else if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0].d;
                s_last  = src_q[0].last;
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
        end
    end

    task automatic push_frame(input int hole_after);
        for (int i = 0; i < pay.size(); i++) begin
            src_q.push_back('{1'b0, (i == pay.size() - 1), pay[i]});
            if (i == hole_after - 1) src_q.push_back('{1'b1, 1'b0, 8'h00});
        end
    endtask

    // Bit-serial reference CRC over the whole body, returns the transmitted FCS value.
    function automatic logic [31:0] model_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input bit pad);
        logic [7:0]  body[$];
        logic [31:0] f;
        body = pay;
        if (pad) while (body.size() < 60) body.push_back(8'h00);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        f = model_fcs(body);
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    endtask

    function automatic int diff_count();
        int n;
        n = (rx_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Called at a negedge; waits (bounded) for tx_en, then records bytes until it drops.
    task automatic grab_frame();
        int t;
        rx_q.delete();
        rx_er_cnt   = 0;
        rx_er_last  = -1;
        rx_busy_all = 1'b1;
        rx_ok       = 1'b0;
        t = 0;
        while (gmii_tx_en !== 1'b1 && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (gmii_tx_en === 1'b1) begin
            rx_ok        = 1'b1;
            rx_start_cyc = cyc;
            t = 0;
            while (gmii_tx_en === 1'b1 && t < 3000) begin
                rx_q.push_back(gmii_txd);
                if (gmii_tx_er === 1'b1) begin
                    rx_er_cnt++;
                    rx_er_last = rx_q.size() - 1;
                end
                if (tx_busy !== 1'b1) rx_busy_all = 1'b0;
                @(negedge clock);
                t++;
            end
        end
    endtask

    // Starts on the first low negedge after a frame; counts low cycles to the next rise.
    task automatic count_gap();
        gap = 1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (gmii_tx_en === 1'b1) break;
            gap++;
        end
    endtask

    task automatic wait_rise(output bit ok);
        int t;
        t = 0;
        while (gmii_tx_en !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        ok = (gmii_tx_en === 1'b1);
    endtask

    task automatic load_check_vector();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (gmii_tx_en !== 1'b0 || gmii_tx_er !== 1'b0)
            begin fails++; $display("FAIL reset_en_er: got en=%b er=%b want 0 0", gmii_tx_en, gmii_tx_er); end
        tests++;
        if (gmii_txd !== 8'h00)
            begin fails++; $display("FAIL reset_txd: got %h want 00", gmii_txd); end
        tests++;
        if (s_ready !== 1'b0 || tx_busy !== 1'b0)
            begin fails++; $display("FAIL reset_ready_busy: got %b %b want 0 0", s_ready, tx_busy); end
        tests++;
        if (frames_sent !== 16'd0 || underruns !== 16'd0)
            begin fails++; $display("FAIL reset_counters: got %h %h want 0 0", frames_sent, underruns); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_check_vector();
        int start;
        load_check_vector();
        build_exp(PAD_ON);
        start = cyc;
        push_frame(-1);
        grab_frame();
        tests++;
        if (!rx_ok) begin fails++; $display("FAIL cv_start: no tx_en within bound"); end
        tests++;
        if (rx_start_cyc != start + 2)
            begin fails++; $display("FAIL cv_latency: tx_en rose at cycle %0d want %0d", rx_start_cyc, start + 2); end
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL cv_bytes: %0d bad, len %0d want %0d", diff_count(), rx_q.size(), exp_q.size()); end
`ifndef GMII_TX_PAD_EN
        tests++;
        if (rx_q.size() != 21 || {rx_q[17], rx_q[18], rx_q[19], rx_q[20]} !== 32'h2639F4CB)
            begin fails++; $display("FAIL cv_fcs_const: len %0d want 21, fcs bytes must be 26 39 F4 CB", rx_q.size()); end
`endif
        tests++;
        if (rx_er_cnt != 0 || !rx_busy_all)
            begin fails++; $display("FAIL cv_er_busy: er count %0d busy_all %0d want 0 1", rx_er_cnt, rx_busy_all); end
        repeat (14) @(negedge clock);
        tests++;
        if (frames_sent !== 16'd1 || tx_busy !== 1'b0)
            begin fails++; $display("FAIL cv_done: frames %0d busy %b want 1 0", frames_sent, tx_busy); end
    endtask

    task automatic test_short_frame();
        pay.delete();
        pay.push_back(8'hAB);
        build_exp(PAD_ON);
        push_frame(-1);
        grab_frame();
        tests++;
        if (rx_q.size() != (PAD_ON ? 72 : 13))
            begin fails++; $display("FAIL short_len: got %0d want %0d", rx_q.size(), PAD_ON ? 72 : 13); end
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL short_bytes: %0d bytes differ from model", diff_count()); end
        repeat (14) @(negedge clock);
        tests++;
        if (frames_sent !== 16'd2)
            begin fails++; $display("FAIL short_count: got %0d want 2", frames_sent); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a[$];
        logic [7:0] exp_b[$];
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'(i));
        build_exp(PAD_ON);
        exp_a = exp_q;
        push_frame(-1);
        pay.delete();
        for (int i = 0; i < 64; i++) pay.push_back(8'(255 - 3 * i));
        build_exp(PAD_ON);
        exp_b = exp_q;
        push_frame(-1);
        exp_q = exp_a;
        grab_frame();
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL b2b_frame1: %0d bytes differ, len %0d", diff_count(), rx_q.size()); end
        count_gap();
        tests++;
        if (gap != 12)
            begin fails++; $display("FAIL b2b_ifg: got %0d idle cycles want 12", gap); end
        exp_q = exp_b;
        grab_frame();
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL b2b_frame2: %0d bytes differ, len %0d", diff_count(), rx_q.size()); end
        repeat (14) @(negedge clock);
        tests++;
        if (frames_sent !== 16'd4)
            begin fails++; $display("FAIL b2b_count: got %0d want 4", frames_sent); end
    endtask

    task automatic test_underrun();
        logic [7:0] full[$];
        logic [15:0] fs0;
        logic [15:0] ur0;
        fs0 = frames_sent;
        ur0 = underruns;
        pay.delete();
        for (int i = 0; i < 100; i++) pay.push_back(8'(3 * i + 7));
        full = pay;
        push_frame(10);
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 10; i++) exp_q.push_back(full[i]);
        exp_q.push_back(8'h00);
        grab_frame();
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL ur_bytes: %0d bytes differ, len %0d want 19", diff_count(), rx_q.size()); end
        tests++;
        if (rx_er_cnt != 1 || rx_er_last != 18)
            begin fails++; $display("FAIL ur_er: er count %0d at %0d want 1 at 18", rx_er_cnt, rx_er_last); end
        tests++;
        if (underruns !== ur0 + 16'd1 || frames_sent !== fs0)
            begin fails++; $display("FAIL ur_counters: ur %0d frames %0d want %0d %0d", underruns, frames_sent, ur0 + 16'd1, fs0); end
        count_gap();
        tests++;
        if (gap != 12)
            begin fails++; $display("FAIL ur_ifg: got %0d idle cycles want 12", gap); end
        pay.delete();
        for (int i = 10; i < 100; i++) pay.push_back(full[i]);
        build_exp(PAD_ON);
        grab_frame();
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL ur_resume: %0d bytes differ, len %0d", diff_count(), rx_q.size()); end
        repeat (14) @(negedge clock);
        tests++;
        if (frames_sent !== fs0 + 16'd1)
            begin fails++; $display("FAIL ur_resume_count: got %0d want %0d", frames_sent, fs0 + 16'd1); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        // Reset during preamble.
        load_check_vector();
        push_frame(-1);
        wait_rise(ok);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        src_q.delete();
        @(negedge clock);
        tests++;
        if (!ok || gmii_tx_en !== 1'b0 || tx_busy !== 1'b0)
            begin fails++; $display("FAIL rst_pre: rose %0d en %b busy %b want 1 0 0", ok, gmii_tx_en, tx_busy); end
        tests++;
        if (frames_sent !== 16'd0 || underruns !== 16'd0)
            begin fails++; $display("FAIL rst_pre_counters: got %0d %0d want 0 0", frames_sent, underruns); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        // Reset during FCS (wire index 18 is the second FCS byte).
        push_frame(-1);
        wait_rise(ok);
        repeat (18) @(negedge clock);
        tests++;
        if (!ok || gmii_tx_en !== 1'b1)
            begin fails++; $display("FAIL rst_fcs_setup: rose %0d en %b want 1 1", ok, gmii_tx_en); end
        reset = 1'b1;
        src_q.delete();
        @(negedge clock);
        tests++;
        if (gmii_tx_en !== 1'b0 || tx_busy !== 1'b0 || frames_sent !== 16'd0)
            begin fails++; $display("FAIL rst_fcs: en %b busy %b frames %0d want 0 0 0", gmii_tx_en, tx_busy, frames_sent); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        // Clean frame after release.
        build_exp(PAD_ON);
        push_frame(-1);
        grab_frame();
        tests++;
        if (diff_count() != 0)
            begin fails++; $display("FAIL rst_after: %0d bytes differ, len %0d", diff_count(), rx_q.size()); end
        repeat (14) @(negedge clock);
        tests++;
        if (frames_sent !== 16'd1 || underruns !== 16'd0)
            begin fails++; $display("FAIL rst_after_count: got %0d %0d want 1 0", frames_sent, underruns); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_check_vector();
        test_short_frame();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1);
    end

endmodule
